// File: rtl/lift_hall_dispatcher.sv
// -----------------------------------------------------------------------------
// lift_hall_dispatcher
//
// Hall-call dispatcher for a two-car elevator group. Landing calls are
// collected into a pending bitmap. Each unassigned call is handed to the
// nearest eligible car by a one-cycle request strobe. The dispatcher tracks
// which car owns which call, and retires a call when any car opens its doors
// at that floor.
//
// Parameters
//   DISPATCH_GAP   idle cycles enforced after each issued request (1..15)
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous, active-high clear of all state
//   hall_call_valid      landing call present this cycle
//   hall_call_floor[2:0] floor of the landing call
//   hall_call_ready      call accepted on valid & ready (low only during reset)
//   current_floorN[2:0]  car N position
//   doorN[1:0]           car N door state, 2'b00 = closed
//   emergency_stopN      car N halted, not eligible for dispatch
//   full_capacityN       car N full, not eligible for dispatch
//   req_validN           one-cycle request strobe to car N
//   req_floorN[2:0]      requested floor; holds its last value between strobes
//   pending_calls[7:0]   outstanding hall calls, one bit per floor
//   assignedN[7:0]       calls currently owned by car N
//
// Build option
//   ESTOP_REASSIGN_EN    when defined, a car under emergency stop drops all of
//                        its assignments every cycle. Its calls then return to
//                        the unassigned pool and can be redispatched to the
//                        other car.
// -----------------------------------------------------------------------------
module lift_hall_dispatcher #(
  parameter int unsigned DISPATCH_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hall_call_valid,
  input  logic [2:0] hall_call_floor,
  output logic       hall_call_ready,
  input  logic [2:0] current_floor1,
  input  logic [2:0] current_floor2,
  input  logic [1:0] door1,
  input  logic [1:0] door2,
  input  logic       emergency_stop1,
  input  logic       emergency_stop2,
  input  logic       full_capacity1,
  input  logic       full_capacity2,
  output logic       req_valid1,
  output logic       req_valid2,
  output logic [2:0] req_floor1,
  output logic [2:0] req_floor2,
  output logic [7:0] pending_calls,
  output logic [7:0] assigned1,
  output logic [7:0] assigned2
);

  // state | meaning
  // ------+---------------------------------------------------------------
  // IDLE  | looking for an unassigned call and an eligible car
  // ISSUE | request strobe on the chosen car; assignment recorded at exit
  // GAP   | gap down-counter running; returns to IDLE at terminal count 1
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(DISPATCH_GAP);

  state_t     state;
  logic [2:0] ptr;
  logic       toggle;     // 0 = car 1 wins the next distance tie
  logic [2:0] lat_floor;
  logic       lat_car2;   // latched choice: 1 = car 2, 0 = car 1
  logic [3:0] gap_cnt;

  logic [7:0] acc_mask;
  logic [7:0] svc_mask;
  logic [7:0] unassigned;
  logic [7:0] issue_mask;
  logic [7:0] assigned1_next;
  logic [7:0] assigned2_next;
  logic       elig1;
  logic       elig2;
  logic       pick_found;
  logic [2:0] pick_floor;
  logic [2:0] dist1;
  logic [2:0] dist2;
  logic       choose_car2;
  logic       tie;
  logic       dispatch_go;

  // Ready is combinational so that it is low only in the reset cycle itself.
  assign hall_call_ready = ~reset;

  assign acc_mask = (hall_call_valid && hall_call_ready) ? (8'b1 << hall_call_floor) : 8'b0;

  // Any car with its doors open serves the floor it is standing at.
  assign svc_mask = ((door1 != 2'b00) ? (8'b1 << current_floor1) : 8'b0)
                  | ((door2 != 2'b00) ? (8'b1 << current_floor2) : 8'b0);

  assign unassigned = pending_calls & ~assigned1 & ~assigned2;

  assign elig1 = ~emergency_stop1 & ~full_capacity1;
  assign elig2 = ~emergency_stop2 & ~full_capacity2;

  // First unassigned floor at or above the round-robin pointer, wrapping 7->0.
  always_comb begin
    pick_found = 1'b0;
    pick_floor = ptr;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = ptr + 3'(i);
      if (!pick_found && unassigned[idx]) begin
        pick_found = 1'b1;
        pick_floor = idx;
      end
    end
  end

  assign dist1 = (current_floor1 >= pick_floor) ? (current_floor1 - pick_floor)
                                                : (pick_floor - current_floor1);
  assign dist2 = (current_floor2 >= pick_floor) ? (current_floor2 - pick_floor)
                                                : (pick_floor - current_floor2);

  always_comb begin
    choose_car2 = 1'b0;
    tie         = 1'b0;
    if (elig1 && elig2) begin
      if (dist1 < dist2) begin
        choose_car2 = 1'b0;
      end else if (dist2 < dist1) begin
        choose_car2 = 1'b1;
      end else begin
        choose_car2 = toggle;
        tie         = 1'b1;
      end
    end else begin
      choose_car2 = ~elig1;
    end
  end

  assign dispatch_go = pick_found && (elig1 || elig2);

  // Service clear is applied after the ISSUE set, so a call served on the
  // same edge it would be assigned stays cleared.
  assign issue_mask = (state == ISSUE) ? (8'b1 << lat_floor) : 8'b0;

  always_comb begin
    assigned1_next = (assigned1 | (lat_car2 ? 8'b0 : issue_mask)) & ~svc_mask;
    assigned2_next = (assigned2 | (lat_car2 ? issue_mask : 8'b0)) & ~svc_mask;
`ifdef ESTOP_REASSIGN_EN
    if (emergency_stop1) begin
      assigned1_next = 8'b0;
    end
    if (emergency_stop2) begin
      assigned2_next = 8'b0;
    end
`else
    // Assignments to a stopped car are retained until that floor is served.
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      toggle        <= 1'b0;
      lat_floor     <= 3'd0;
      lat_car2      <= 1'b0;
      gap_cnt       <= 4'd0;
      pending_calls <= 8'b0;
      assigned1     <= 8'b0;
      assigned2     <= 8'b0;
      req_valid1    <= 1'b0;
      req_valid2    <= 1'b0;
      req_floor1    <= 3'd0;
      req_floor2    <= 3'd0;
    end else begin
      pending_calls <= (pending_calls | acc_mask) & ~svc_mask;
      assigned1     <= assigned1_next;
      assigned2     <= assigned2_next;
      req_valid1    <= 1'b0;
      req_valid2    <= 1'b0;

      case (state)
        IDLE: begin
          if (dispatch_go) begin
            lat_floor <= pick_floor;
            lat_car2  <= choose_car2;
            if (tie) begin
              toggle <= ~toggle;
            end
            // Strobe is registered here so it is high for the whole ISSUE cycle.
            if (choose_car2) begin
              req_valid2 <= 1'b1;
              req_floor2 <= pick_floor;
            end else begin
              req_valid1 <= 1'b1;
              req_floor1 <= pick_floor;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          ptr     <= lat_floor + 3'd1;
          gap_cnt <= GAP_LOAD;
          state   <= GAP;
        end

        GAP: begin
          if (gap_cnt == 4'd1) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lift_hall_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_lift_hall_dispatcher
//
// Directed scenarios for the hall-call dispatcher. Each scenario pushes the
// request strobes it expects, as (car, floor) pairs, onto a scoreboard. A
// monitor process pops one entry for every strobe the design produces.
// Scenario tasks also check bitmaps, latency and strobe spacing inline.
// -----------------------------------------------------------------------------
module tb_lift_hall_dispatcher;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       hall_call_valid;
  logic [2:0] hall_call_floor;
  logic       hall_call_ready;
  logic [2:0] current_floor1, current_floor2;
  logic [1:0] door1, door2;
  logic       emergency_stop1, emergency_stop2;
  logic       full_capacity1, full_capacity2;
  logic       req_valid1, req_valid2;
  logic [2:0] req_floor1, req_floor2;
  logic [7:0] pending_calls, assigned1, assigned2;

  always #5 clk = ~clk;

  lift_hall_dispatcher #(.DISPATCH_GAP(GAP)) dut (
    .clk             (clk),
    .reset           (reset),
    .hall_call_valid (hall_call_valid),
    .hall_call_floor (hall_call_floor),
    .hall_call_ready (hall_call_ready),
    .current_floor1  (current_floor1),
    .current_floor2  (current_floor2),
    .door1           (door1),
    .door2           (door2),
    .emergency_stop1 (emergency_stop1),
    .emergency_stop2 (emergency_stop2),
    .full_capacity1  (full_capacity1),
    .full_capacity2  (full_capacity2),
    .req_valid1      (req_valid1),
    .req_valid2      (req_valid2),
    .req_floor1      (req_floor1),
    .req_floor2      (req_floor2),
    .pending_calls   (pending_calls),
    .assigned1       (assigned1),
    .assigned2       (assigned2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ncyc = 0;
  int accept_n = 0;
  int strobe_total = 0;
  int s1_total = 0;
  int strobe_hist[$];
  int exp_car[$];
  int exp_floor[$];

  task automatic monitor();
    forever begin
      @(negedge clk);
      ncyc++;
      if (req_valid1 === 1'b1 && req_valid2 === 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL strobe_exclusive: both req_valid high at cycle %0d, required at most one", ncyc);
      end
      if (req_valid1 === 1'b1 || req_valid2 === 1'b1) begin
        int got_car, got_fl, want_car, want_fl;
        strobe_total++;
        if (req_valid1 === 1'b1) s1_total++;
        strobe_hist.push_back(ncyc);
        got_car = (req_valid1 === 1'b1) ? 1 : 2;
        got_fl  = (req_valid1 === 1'b1) ? int'(req_floor1) : int'(req_floor2);
        n_cmp++;
        if (exp_car.size() == 0) begin
          n_err++;
          $display("FAIL strobe_unexpected: got car %0d floor %0d, required no strobe", got_car, got_fl);
        end else begin
          want_car = exp_car.pop_front();
          want_fl  = exp_floor.pop_front();
          if (got_car !== want_car || got_fl !== want_fl) begin
            n_err++;
            $display("FAIL strobe_match: got car %0d floor %0d, required car %0d floor %0d",
                     got_car, got_fl, want_car, want_fl);
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    hall_call_valid = 1'b0;
    hall_call_floor = 3'd0;
    current_floor1 = 3'd0; current_floor2 = 3'd0;
    door1 = 2'b00; door2 = 2'b00;
    emergency_stop1 = 1'b0; emergency_stop2 = 1'b0;
    full_capacity1 = 1'b0; full_capacity2 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push_exp(input int car, input int fl);
    exp_car.push_back(car);
    exp_floor.push_back(fl);
  endtask

  task automatic send_call(input int fl);
    hall_call_valid = 1'b1;
    hall_call_floor = 3'(fl);
    @(posedge clk); #1;
    hall_call_valid = 1'b0;
    accept_n = ncyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int target, input int budget, input string name);
    int n = 0;
    while (strobe_total < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_cmp++;
    if (strobe_total < target) begin
      n_err++;
      $display("FAIL %s_timeout: strobes seen %0d, required %0d within %0d cycles", name, strobe_total, target, budget);
    end
  endtask

  task automatic test_reset();
    int base;
    apply_reset();
    base = strobe_total;
    push_exp(1, 2);
    send_call(2);
    wait_strobe(base + 1, 10, "reset_pre");
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (hall_call_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready_low: got %b, required 0", hall_call_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (hall_call_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_high: got %b, required 1", hall_call_ready);
    end
    n_cmp++;
    if (pending_calls !== 8'h00 || assigned1 !== 8'h00 || assigned2 !== 8'h00) begin
      n_err++; $display("FAIL reset_bitmaps: got pend %h a1 %h a2 %h, required all 00", pending_calls, assigned1, assigned2);
    end
    n_cmp++;
    if (req_valid1 !== 1'b0 || req_valid2 !== 1'b0 || req_floor1 !== 3'd0 || req_floor2 !== 3'd0) begin
      n_err++; $display("FAIL reset_req: got v1 %b v2 %b f1 %0d f2 %0d, required 0 0 0 0", req_valid1, req_valid2, req_floor1, req_floor2);
    end
  endtask

  task automatic test_basic();
    int base;
    apply_reset();
    base = strobe_total;
    push_exp(1, 3);
    send_call(3);
    @(negedge clk);
    n_cmp++;
    if (pending_calls !== 8'b0000_1000) begin
      n_err++; $display("FAIL basic_pending: got %b, required 00001000", pending_calls);
    end
    wait_strobe(base + 1, 10, "basic");
    n_cmp++;
    if (strobe_hist[strobe_hist.size()-1] !== accept_n + 2) begin
      n_err++; $display("FAIL basic_latency: strobe at cycle %0d, required %0d", strobe_hist[strobe_hist.size()-1], accept_n + 2);
    end
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'b0000_1000 || assigned2 !== 8'h00) begin
      n_err++; $display("FAIL basic_assigned: got a1 %b a2 %b, required 00001000 00000000", assigned1, assigned2);
    end
  endtask

  task automatic test_nearest();
    int base, base1;
    apply_reset();
    base = strobe_total; base1 = s1_total;
    current_floor1 = 3'd0; current_floor2 = 3'd5;
    push_exp(2, 6);
    send_call(6);
    wait_strobe(base + 1, 10, "nearest");
    @(negedge clk);
    n_cmp++;
    if (assigned2 !== 8'b0100_0000 || assigned1 !== 8'h00) begin
      n_err++; $display("FAIL nearest_assigned: got a1 %b a2 %b, required 00000000 01000000", assigned1, assigned2);
    end
    n_cmp++;
    if (s1_total - base1 !== 0) begin
      n_err++; $display("FAIL nearest_car1_quiet: got %0d car1 strobes, required 0", s1_total - base1);
    end
    // Distance-zero call at car 1's own floor with doors closed
    current_floor1 = 3'd4;
    push_exp(1, 4);
    send_call(4);
    wait_strobe(base + 2, 20, "dist0");
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'b0001_0000) begin
      n_err++; $display("FAIL dist0_assigned: got %b, required 00010000", assigned1);
    end
  endtask

  task automatic test_back_to_back();
    int base, sz;
    apply_reset();
    base = strobe_total;
    current_floor1 = 3'd2; current_floor2 = 3'd2;
    push_exp(1, 4);
    push_exp(2, 0);
    send_call(4);
    send_call(0);
    wait_strobe(base + 2, 20, "b2b");
    sz = strobe_hist.size();
    n_cmp++;
    if (sz < 2 || strobe_hist[sz-1] - strobe_hist[sz-2] !== GAP + 2) begin
      n_err++; $display("FAIL b2b_spacing: got %0d cycles, required %0d", (sz < 2) ? -1 : strobe_hist[sz-1] - strobe_hist[sz-2], GAP + 2);
    end
    n_cmp++;
    if (req_floor1 !== 3'd4) begin
      n_err++; $display("FAIL b2b_floor1_hold: got %0d, required 4", req_floor1);
    end
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'b0001_0000 || assigned2 !== 8'b0000_0001) begin
      n_err++; $display("FAIL b2b_assigned: got a1 %b a2 %b, required 00010000 00000001", assigned1, assigned2);
    end
  endtask

  task automatic test_ineligible();
    int base;
    apply_reset();
    base = strobe_total;
    full_capacity2 = 1'b1;
    emergency_stop1 = 1'b1;
    send_call(5);
    send_call(5);
    idle(10);
    @(negedge clk);
    n_cmp++;
    if (pending_calls !== 8'b0010_0000) begin
      n_err++; $display("FAIL inelig_pending: got %b, required 00100000", pending_calls);
    end
    n_cmp++;
    if (strobe_total - base !== 0) begin
      n_err++; $display("FAIL inelig_quiet: got %0d strobes, required 0", strobe_total - base);
    end
    push_exp(1, 5);
    emergency_stop1 = 1'b0;
    wait_strobe(base + 1, 10, "inelig");
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'b0010_0000 || assigned2 !== 8'h00) begin
      n_err++; $display("FAIL inelig_assigned: got a1 %b a2 %b, required 00100000 00000000", assigned1, assigned2);
    end
  endtask

  task automatic test_service();
    int base;
    apply_reset();
    base = strobe_total;
    current_floor1 = 3'd6; current_floor2 = 3'd0;
    push_exp(1, 7);
    send_call(7);
    wait_strobe(base + 1, 10, "service");
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'b1000_0000 || pending_calls !== 8'b1000_0000) begin
      n_err++; $display("FAIL service_before: got a1 %b pend %b, required 10000000 10000000", assigned1, pending_calls);
    end
    current_floor1 = 3'd7;
    door1 = 2'b01;
    hall_call_valid = 1'b1;
    hall_call_floor = 3'd7;
    @(posedge clk); #1;
    hall_call_valid = 1'b0;
    door1 = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (pending_calls !== 8'h00 || assigned1 !== 8'h00) begin
      n_err++; $display("FAIL service_clear: got pend %b a1 %b, required 00000000 00000000", pending_calls, assigned1);
    end
    idle(5);
    @(negedge clk);
    n_cmp++;
    if (pending_calls !== 8'h00 || strobe_total - base !== 1) begin
      n_err++; $display("FAIL service_discard: got pend %b strobes %0d, required 00000000 1", pending_calls, strobe_total - base);
    end
  endtask

  task automatic test_reset_mid_issue();
    int base;
    apply_reset();
    base = strobe_total;
    push_exp(1, 1);
    send_call(1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_valid1 !== 1'b0 || assigned1 !== 8'h00 || pending_calls !== 8'h00) begin
      n_err++; $display("FAIL midreset_clear: got v1 %b a1 %b pend %b, required 0 00000000 00000000", req_valid1, assigned1, pending_calls);
    end
    idle(6);
    n_cmp++;
    if (strobe_total - base !== 1) begin
      n_err++; $display("FAIL midreset_strobes: got %0d, required 1", strobe_total - base);
    end
  endtask

  task automatic test_estop();
    int base;
    apply_reset();
    base = strobe_total;
    current_floor1 = 3'd2; current_floor2 = 3'd6;
    push_exp(1, 3);
    send_call(3);
    wait_strobe(base + 1, 10, "estop");
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'b0000_1000) begin
      n_err++; $display("FAIL estop_assigned: got %b, required 00001000", assigned1);
    end
    emergency_stop1 = 1'b1;
`ifdef ESTOP_REASSIGN_EN
    push_exp(2, 3);
    wait_strobe(base + 2, 20, "estop_redispatch");
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'h00 || assigned2 !== 8'b0000_1000) begin
      n_err++; $display("FAIL estop_reassign: got a1 %b a2 %b, required 00000000 00001000", assigned1, assigned2);
    end
`else
    idle(10);
    @(negedge clk);
    n_cmp++;
    if (assigned1 !== 8'b0000_1000 || pending_calls !== 8'b0000_1000 || assigned2 !== 8'h00) begin
      n_err++; $display("FAIL estop_retain: got a1 %b a2 %b pend %b, required 00001000 00000000 00001000", assigned1, assigned2, pending_calls);
    end
    n_cmp++;
    if (strobe_total - base !== 1) begin
      n_err++; $display("FAIL estop_no_redispatch: got %0d strobes, required 1", strobe_total - base);
    end
`endif
    emergency_stop1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hall_call_valid = 1'b0;
    hall_call_floor = 3'd0;
    current_floor1 = 3'd0; current_floor2 = 3'd0;
    door1 = 2'b00; door2 = 2'b00;
    emergency_stop1 = 1'b0; emergency_stop2 = 1'b0;
    full_capacity1 = 1'b0; full_capacity2 = 1'b0;
    fork
      monitor();
    join_none

    test_reset();
    test_basic();
    test_nearest();
    test_back_to_back();
    test_ineligible();
    test_service();
    test_reset_mid_issue();
    test_estop();

    idle(3);
    n_cmp++;
    if (exp_car.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d expected strobes never seen, required 0", exp_car.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
